// File: rtl/vgachargen_scanout.sv
// VGA text-mode scan-out: sync timing, map/font fetch, palette, blinking cursor.
// Pixel rate is a clock enable derived from clk_i; all stages advance on pix_en.
module vgachargen_scanout #(
   parameter int CLK_DIV      = 4,
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int CHAR_W       = 8,
   parameter int CHAR_H       = 16,
   parameter int RGB_W        = 4,
   parameter int BLINK_FRAMES = 32,
   localparam int COLS    = H_ACTIVE / CHAR_W,
   localparam int ROWS    = V_ACTIVE / CHAR_H,
   localparam int MAP_AW  = $clog2(COLS * ROWS),
   localparam int FONT_AW = 8 + $clog2(CHAR_H)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               cursor_en_i,
   input  logic [MAP_AW-1:0]  cursor_addr_i,
   output logic [MAP_AW-1:0]  map_addr_o,
   input  logic [7:0]         map_ch_i,
   input  logic [7:0]         map_col_i,
   output logic [FONT_AW-1:0] font_addr_o,
   input  logic [CHAR_W-1:0]  font_row_i,
   output logic [RGB_W-1:0]   R_o,
   output logic [RGB_W-1:0]   G_o,
   output logic [RGB_W-1:0]   B_o,
   output logic               hsync_o,
   output logic               vsync_o,
   output logic               vblank_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CELLS   = COLS * ROWS;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int DW = $clog2(CLK_DIV);
   localparam int XW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
   localparam int YW = $clog2(CHAR_H);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [RGB_W-1:0] FULL = '1;
   localparam logic [RGB_W-1:0] HALF = FULL >> 1;

   logic [DW-1:0] div_cnt;
   logic          pix_en;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_end;
   logic          v_end;
   logic [BW-1:0] frame_cnt;
   logic          phase;

   assign pix_en = (div_cnt == DW'(CLK_DIV - 1));
   assign h_end  = (h_cnt == HW'(H_TOTAL - 1));
   assign v_end  = (v_cnt == VW'(V_TOTAL - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt <= '0;
      end else if (pix_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // phase 0 shows the cursor; it flips every BLINK_FRAMES frames
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (pix_en && h_end && v_end) begin
         if (frame_cnt == BW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   logic c_act;
   logic c_hs;
   logic c_vs;
   logic c_vb;

   always_comb begin
      c_act = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
      c_hs  = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                (h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
      c_vs  = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                (v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
      c_vb  = (v_cnt >= VW'(V_ACTIVE));
   end

   logic [XW-1:0] s0_x;
   logic [YW-1:0] s0_y;
   logic          s0_act;
   logic          s0_hs;
   logic          s0_vs;
   logic          s0_vb;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         map_addr_o <= '0;
         s0_x       <= '0;
         s0_y       <= '0;
         s0_act     <= 1'b0;
         s0_hs      <= 1'b1;
         s0_vs      <= 1'b1;
         s0_vb      <= 1'b0;
      end else if (pix_en) begin
         map_addr_o <= MAP_AW'((int'(v_cnt) / CHAR_H) * COLS +
                               int'(h_cnt) / CHAR_W);
         s0_x       <= XW'(int'(h_cnt) % CHAR_W);
         s0_y       <= YW'(int'(v_cnt) % CHAR_H);
         s0_act     <= c_act;
         s0_hs      <= c_hs;
         s0_vs      <= c_vs;
         s0_vb      <= c_vb;
      end
   end

   logic [XW-1:0] s1_x;
   logic [7:0]    s1_col;
   logic          s1_hit;
   logic          s1_act;
   logic          s1_hs;
   logic          s1_vs;
   logic          s1_vb;
   logic          hit;

   assign hit = cursor_en_i && (int'(cursor_addr_i) < CELLS) &&
                (map_addr_o == cursor_addr_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         font_addr_o <= '0;
         s1_x        <= '0;
         s1_col      <= '0;
         s1_hit      <= 1'b0;
         s1_act      <= 1'b0;
         s1_hs       <= 1'b1;
         s1_vs       <= 1'b1;
         s1_vb       <= 1'b0;
      end else if (pix_en) begin
         font_addr_o <= {map_ch_i, s0_y};
         s1_x        <= s0_x;
         s1_col      <= map_col_i;
         s1_hit      <= hit;
         s1_act      <= s0_act;
         s1_hs       <= s0_hs;
         s1_vs       <= s0_vs;
         s1_vb       <= s0_vb;
      end
   end

   logic [XW-1:0] bit_sel;
   logic          pix_bit;
   logic          swap;
   logic [3:0]    idx;

   always_comb begin
      bit_sel = XW'(CHAR_W - 1) - s1_x;
      pix_bit = font_row_i[bit_sel];
      swap    = s1_hit && !phase;
      idx     = (pix_bit ^ swap) ? s1_col[7:4] : s1_col[3:0];
   end

   logic [3:0] s2_idx;
   logic       s2_act;
   logic       s2_hs;
   logic       s2_vs;
   logic       s2_vb;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_idx <= '0;
         s2_act <= 1'b0;
         s2_hs  <= 1'b1;
         s2_vs  <= 1'b1;
         s2_vb  <= 1'b0;
      end else if (pix_en) begin
         s2_idx <= idx;
         s2_act <= s1_act;
         s2_hs  <= s1_hs;
         s2_vs  <= s1_vs;
         s2_vb  <= s1_vb;
      end
   end

   function automatic logic [RGB_W-1:0] chan(input logic on,
                                             input logic bright);
      return on ? (bright ? FULL : HALF) : '0;
   endfunction

   logic show;
   assign show = s2_act && en_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         R_o      <= '0;
         G_o      <= '0;
         B_o      <= '0;
         hsync_o  <= 1'b1;
         vsync_o  <= 1'b1;
         vblank_o <= 1'b0;
      end else if (pix_en) begin
         R_o      <= show ? chan(s2_idx[2], s2_idx[3]) : '0;
         G_o      <= show ? chan(s2_idx[1], s2_idx[3]) : '0;
         B_o      <= show ? chan(s2_idx[0], s2_idx[3]) : '0;
         hsync_o  <= s2_hs;
         vsync_o  <= s2_vs;
         vblank_o <= s2_vb;
      end
   end

endmodule

// File: tb/tb_vgachargen_scanout.sv
// Bench: small-geometry instance for rendering/cursor/blank vectors,
// default-geometry instance for line timing and reset-restart checks.
module tb_vgachargen_scanout;

   localparam int HT = 24;
   localparam int VT = 16;
   localparam int FR = HT * VT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic ce = 1'b0;
   logic [2:0] ca = '0;

   logic [2:0]  map_addr;
   logic [7:0]  map_ch;
   logic [7:0]  map_col;
   logic [9:0]  font_addr;
   logic [7:0]  font_row;
   logic [3:0]  r, g, b;
   logic        hs, vs, vb;

   logic [11:0] d_map_addr;
   logic [11:0] d_font_addr;
   logic [3:0]  d_r, d_g, d_b;
   logic        d_hs, d_vs, d_vb;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   vgachargen_scanout #(
      .CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CHAR_W(8), .CHAR_H(4), .RGB_W(4), .BLINK_FRAMES(2)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en),
      .cursor_en_i(ce), .cursor_addr_i(ca),
      .map_addr_o(map_addr), .map_ch_i(map_ch), .map_col_i(map_col),
      .font_addr_o(font_addr), .font_row_i(font_row),
      .R_o(r), .G_o(g), .B_o(b),
      .hsync_o(hs), .vsync_o(vs), .vblank_o(vb)
   );

   vgachargen_scanout dut_def (
      .clk_i(clk), .rst_ni(rst_n), .en_i(1'b1),
      .cursor_en_i(1'b0), .cursor_addr_i(12'd0),
      .map_addr_o(d_map_addr), .map_ch_i(8'h00), .map_col_i(8'h00),
      .font_addr_o(d_font_addr), .font_row_i(8'h00),
      .R_o(d_r), .G_o(d_g), .B_o(d_b),
      .hsync_o(d_hs), .vsync_o(d_vs), .vblank_o(d_vb)
   );

   // sync-read RAM models, 1-clk latency
   always @(posedge clk) begin
      case (map_addr)
         3'd0: begin map_ch <= 8'h41; map_col <= 8'hF1; end
         3'd1: begin map_ch <= 8'h42; map_col <= 8'h2C; end
         3'd3: begin map_ch <= 8'h43; map_col <= 8'h5A; end
         default: begin map_ch <= 8'h00; map_col <= 8'h07; end
      endcase
      case (font_addr[9:2])
         8'h41: font_row <= 8'h80;
         8'h42: font_row <= 8'hF0;
         8'h43: font_row <= 8'h01;
         default: font_row <= 8'h00;
      endcase
   end

   typedef struct {
      int f; int x; int y;
      logic en; logic ce; logic [2:0] ca;
      logic [11:0] rgb; logic hs; logic vs; logic vb;
   } vec_t;

   vec_t tv[40];
   int nv = 0;
   int base;

   task automatic add(int f, int x, int y, logic e, logic c,
                      logic [2:0] a, logic [11:0] rgb,
                      logic h, logic v, logic bl);
      tv[nv] = '{f, x, y, e, c, a, rgb, h, v, bl};
      nv++;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(int t);
      if (cyc > t) begin
         checks++;
         errors++;
         $display("FAIL overrun: at cycle %0d want %0d", cyc, t);
      end
      while (cyc < t) @(negedge clk);
   endtask

   initial begin
      add(0, 0, 0, 1, 0, 0, 12'hFFF, 1, 1, 0);
      add(0, 1, 0, 1, 0, 0, 12'h007, 1, 1, 0);
      add(0, 8, 0, 1, 0, 0, 12'h070, 1, 1, 0);
      add(0, 12, 0, 1, 0, 0, 12'hF00, 1, 1, 0);
      add(0, 16, 0, 1, 0, 0, 12'h000, 1, 1, 0);
      add(0, 18, 0, 1, 0, 0, 12'h000, 0, 1, 0);
      add(0, 20, 0, 1, 0, 0, 12'h000, 0, 1, 0);
      add(0, 21, 0, 1, 0, 0, 12'h000, 1, 1, 0);
      add(0, 14, 4, 1, 0, 0, 12'h0F0, 1, 1, 0);
      add(0, 15, 4, 1, 0, 0, 12'h707, 1, 1, 0);
      add(0, 3, 9, 1, 0, 0, 12'h777, 1, 1, 0);
      add(0, 15, 11, 1, 0, 0, 12'h777, 1, 1, 0);
      add(0, 0, 12, 1, 0, 0, 12'h000, 1, 1, 1);
      add(0, 5, 13, 1, 0, 0, 12'h000, 1, 0, 1);
      add(0, 19, 14, 1, 0, 0, 12'h000, 0, 0, 1);
      add(0, 0, 15, 1, 0, 0, 12'h000, 1, 1, 1);
      add(1, 0, 0, 1, 1, 0, 12'h007, 1, 1, 0);
      add(1, 1, 0, 1, 1, 0, 12'hFFF, 1, 1, 0);
      add(1, 8, 0, 1, 1, 0, 12'h070, 1, 1, 0);
      add(2, 0, 0, 1, 1, 0, 12'hFFF, 1, 1, 0);
      add(2, 1, 0, 1, 1, 0, 12'h007, 1, 1, 0);
      add(3, 14, 4, 1, 1, 3, 12'h0F0, 1, 1, 0);
      add(3, 15, 4, 1, 1, 3, 12'h707, 1, 1, 0);
      add(4, 0, 0, 1, 1, 3, 12'hFFF, 1, 1, 0);
      add(4, 14, 4, 1, 1, 3, 12'h707, 1, 1, 0);
      add(4, 15, 4, 1, 1, 3, 12'h0F0, 1, 1, 0);
      add(5, 0, 0, 1, 1, 7, 12'hFFF, 1, 1, 0);
      add(5, 1, 0, 1, 1, 7, 12'h007, 1, 1, 0);
      add(5, 15, 4, 1, 1, 7, 12'h707, 1, 1, 0);
      add(6, 0, 0, 0, 1, 0, 12'h000, 1, 1, 0);
      add(6, 18, 0, 0, 1, 0, 12'h000, 0, 1, 0);
      add(6, 5, 13, 0, 1, 0, 12'h000, 1, 0, 1);

      repeat (3) @(negedge clk);
      chk("rst_map_addr", 32'(map_addr), 0);
      chk("rst_font_addr", 32'(font_addr), 0);
      chk("rst_rgb", 32'({r, g, b}), 0);
      chk("rst_syncs", 32'({hs, vs, vb}), 32'b110);
      chk("rst_def_syncs", 32'({d_hs, d_vs, d_vb}), 32'b110);
      rst_n = 1'b1;
      base = cyc;

      fork
         begin
            for (int i = 0; i < nv; i++) begin
               int k;
               if (i == 0 || tv[i].f != tv[i-1].f) begin
                  en = tv[i].en;
                  ce = tv[i].ce;
                  ca = tv[i].ca;
               end
               k = tv[i].f * FR + tv[i].y * HT + tv[i].x;
               wait_cyc(base + 2 * (k + 4));
               chk($sformatf("vec%0d f%0d (%0d,%0d)", i, tv[i].f,
                             tv[i].x, tv[i].y),
                   32'({r, g, b, hs, vs, vb}),
                   32'({tv[i].rgb, tv[i].hs, tv[i].vs, tv[i].vb}));
            end
            wait_cyc(base + 2 * (8 * FR + 5 * HT + 9 + 1));
            chk("map_addr x9 y5", 32'(map_addr), 3);
            wait_cyc(base + 2 * (8 * FR + 5 * HT + 9 + 2));
            chk("font_addr x9 y5", 32'(font_addr), 32'h10D);
            wait_cyc(base + 2 * (8 * FR + 11 * HT + 15 + 1));
            chk("map_addr last cell", 32'(map_addr), 5);
            en = 1'b1;
            ce = 1'b0;
         end
         begin
            wait_cyc(base + 2639);
            chk("def_hs before fall", 32'(d_hs), 1);
            wait_cyc(base + 2640);
            chk("def_hs first fall", 32'(d_hs), 0);
            wait_cyc(base + 3023);
            chk("def_hs low end", 32'(d_hs), 0);
            wait_cyc(base + 3024);
            chk("def_hs rise", 32'(d_hs), 1);
            wait_cyc(base + 5839);
            chk("def_hs before 2nd fall", 32'(d_hs), 1);
            wait_cyc(base + 5840);
            chk("def_hs 2nd fall", 32'(d_hs), 0);
         end
      join

      // reset in the middle of a rendered pixel
      wait_cyc(base + 2 * (9 * FR + 4));
      chk("pre_reset rgb", 32'({r, g, b}), 32'hFFF);
      #2 rst_n = 1'b0;
      #1;
      chk("async rgb", 32'({r, g, b}), 0);
      chk("async map_addr", 32'(map_addr), 0);
      chk("async syncs", 32'({hs, vs, vb}), 32'b110);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      wait_cyc(base + 2);
      chk("restart map_addr 0", 32'(map_addr), 0);
      wait_cyc(base + 7);
      chk("restart rgb latency", 32'({r, g, b}), 0);
      wait_cyc(base + 8);
      chk("restart pixel 0,0", 32'({r, g, b}), 32'hFFF);
      wait_cyc(base + 10);
      chk("restart pixel 1,0", 32'({r, g, b}), 32'h007);
      wait_cyc(base + 18);
      chk("restart map_addr x8", 32'(map_addr), 1);
      wait_cyc(base + 2639);
      chk("restart def_hs high", 32'(d_hs), 1);
      wait_cyc(base + 2640);
      chk("restart def_hs fall", 32'(d_hs), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
